// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and multi-cycle stalls,
// redirect squash sequencing and saturating stall/flush counters. state_o: 0 RUN, 1 MC_WAIT, 2 SQUASH.
module pipe_hazard_ctrl #(
    parameter int XLEN        = 32,
    parameter int NFWD        = 2,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CW          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 de_valid_i,
    input  logic [4:0]           de_rs1_i,
    input  logic [4:0]           de_rs2_i,
    input  logic                 de_use_rs1_i,
    input  logic                 de_use_rs2_i,
    input  logic [XLEN-1:0]      de_rs1_data_i,
    input  logic [XLEN-1:0]      de_rs2_data_i,
    input  logic [5*NFWD-1:0]    src_rd_i,
    input  logic [NFWD-1:0]      src_we_i,
    input  logic [NFWD-1:0]      src_is_load_i,
    input  logic [XLEN*NFWD-1:0] src_data_i,
    input  logic                 redirect_i,
    input  logic                 mc_start_i,
    input  logic                 mc_done_i,
    input  logic                 cnt_clr_i,
    output logic [XLEN-1:0]      rs1_o,
    output logic [XLEN-1:0]      rs2_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic [CW-1:0]        stall_cycles_o,
    output logic [CW-1:0]        flush_events_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {RUN = 2'd0, MC_WAIT = 2'd1, SQUASH = 2'd2} state_t;

    localparam int FCW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [FCW-1:0] RELOAD = FCW'(FLUSH_DEPTH - 1);

    // Returns {load_use, operand}; the loop runs oldest-first so the youngest match wins.
    function automatic logic [XLEN:0] fwd_sel(
        input logic [4:0]           addr,
        input logic                 use_rs,
        input logic [XLEN-1:0]      rf_data,
        input logic [5*NFWD-1:0]    rd,
        input logic [NFWD-1:0]      we,
        input logic [NFWD-1:0]      ld,
        input logic [XLEN*NFWD-1:0] data
    );
        logic [XLEN:0] r;
        r = {1'b0, rf_data};
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (use_rs && (addr != 5'd0) && we[i] && (rd[5*i +: 5] == addr))
                r = {ld[i] && (i < LOAD_LAT), data[XLEN*i +: XLEN]};
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [FCW-1:0]  sq_cnt_q, sq_cnt_d;
    logic [CW-1:0]   stall_cyc_q, stall_cyc_d;
    logic [CW-1:0]   flush_evt_q, flush_evt_d;
    logic [XLEN:0]   fwd1, fwd2;
    logic            load_use;
    logic            stall, flush, redirect_acc;

    always_comb begin
        fwd1     = fwd_sel(de_rs1_i, de_use_rs1_i, de_rs1_data_i, src_rd_i, src_we_i,
                           src_is_load_i, src_data_i);
        fwd2     = fwd_sel(de_rs2_i, de_use_rs2_i, de_rs2_data_i, src_rd_i, src_we_i,
                           src_is_load_i, src_data_i);
        load_use = de_valid_i && (fwd1[XLEN] || fwd2[XLEN]);
    end

    assign rs1_o = fwd1[XLEN-1:0];
    assign rs2_o = fwd2[XLEN-1:0];

    always_comb begin
        state_d      = state_q;
        sq_cnt_d     = sq_cnt_q;
        stall        = 1'b0;
        flush        = 1'b0;
        redirect_acc = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_i) begin
                    flush        = 1'b1;
                    redirect_acc = 1'b1;
                    sq_cnt_d     = RELOAD;
                    state_d      = SQUASH;
                end else begin
                    stall = load_use;
                    if (mc_start_i && de_valid_i && !load_use) state_d = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if (mc_done_i) state_d = RUN;
                else           stall   = 1'b1;
            end
            SQUASH: begin
                flush = 1'b1;
                if (redirect_i) begin
                    redirect_acc = 1'b1;
                    sq_cnt_d     = RELOAD;
                end else if (sq_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    sq_cnt_d = sq_cnt_q - FCW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Reset gating keeps the combinational load-use path from leaking out during reset.
    assign stall_o = rst_n && stall;
    assign flush_o = rst_n && flush;
    assign state_o = state_q;

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        flush_evt_d = flush_evt_q;
        if (cnt_clr_i) begin
            stall_cyc_d = '0;
            flush_evt_d = '0;
        end else begin
            if (stall_o && (stall_cyc_q != {CW{1'b1}}))      stall_cyc_d = stall_cyc_q + CW'(1);
            if (redirect_acc && (flush_evt_q != {CW{1'b1}})) flush_evt_d = flush_evt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            sq_cnt_q    <= '0;
            stall_cyc_q <= '0;
            flush_evt_q <= '0;
        end else begin
            state_q     <= state_d;
            sq_cnt_q    <= sq_cnt_d;
            stall_cyc_q <= stall_cyc_d;
            flush_evt_q <= flush_evt_d;
        end
    end

    assign stall_cycles_o = stall_cyc_q;
    assign flush_events_o = flush_evt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model that tracks remaining squash cycles and a multi-cycle busy flag.
module tb_pipe_hazard_ctrl;

    localparam int XLEN        = 32;
    localparam int NFWD        = 2;
    localparam int LOAD_LAT    = 1;
    localparam int FLUSH_DEPTH = 2;
    localparam int CW          = 4;
    localparam int MAXC        = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 de_valid, de_use_rs1, de_use_rs2;
    logic [4:0]           de_rs1, de_rs2;
    logic [XLEN-1:0]      de_rs1_data, de_rs2_data;
    logic [5*NFWD-1:0]    src_rd;
    logic [NFWD-1:0]      src_we, src_is_load;
    logic [XLEN*NFWD-1:0] src_data;
    logic                 redirect, mc_start, mc_done, cnt_clr;
    logic [XLEN-1:0]      rs1_o, rs2_o;
    logic                 stall_o, flush_o;
    logic [CW-1:0]        stall_cycles_o, flush_events_o;
    logic [1:0]           dbg_state;

    int checks = 0;
    int passed = 0;

    // Reference model state
    int              m_sq_rem;
    bit              m_mc;
    int              m_sc, m_fe;
    bit              m_l1, m_l2, m_lu, m_acc;
    logic            exp_stall, exp_flush;
    logic [XLEN-1:0] exp_rs1, exp_rs2;

    pipe_hazard_ctrl #(
        .XLEN(XLEN), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT), .FLUSH_DEPTH(FLUSH_DEPTH), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .de_valid_i(de_valid), .de_rs1_i(de_rs1), .de_rs2_i(de_rs2),
        .de_use_rs1_i(de_use_rs1), .de_use_rs2_i(de_use_rs2),
        .de_rs1_data_i(de_rs1_data), .de_rs2_data_i(de_rs2_data),
        .src_rd_i(src_rd), .src_we_i(src_we), .src_is_load_i(src_is_load), .src_data_i(src_data),
        .redirect_i(redirect), .mc_start_i(mc_start), .mc_done_i(mc_done), .cnt_clr_i(cnt_clr),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .stall_o(stall_o), .flush_o(flush_o),
        .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o), .state_o(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void ref_operand(input logic [4:0] a, input logic u, input logic [XLEN-1:0] rf,
                                        output logic [XLEN-1:0] val, output bit lu);
        val = rf;
        lu  = 1'b0;
        if (u && a != 5'd0) begin
            for (int i = 0; i < NFWD; i++) begin
                if (src_we[i] && src_rd[5*i +: 5] == a) begin
                    val = src_data[XLEN*i +: XLEN];
                    lu  = src_is_load[i] && (i < LOAD_LAT);
                    break;
                end
            end
        end
    endfunction

    task automatic model_eval();
        ref_operand(de_rs1, de_use_rs1, de_rs1_data, exp_rs1, m_l1);
        ref_operand(de_rs2, de_use_rs2, de_rs2_data, exp_rs2, m_l2);
        m_lu      = de_valid && (m_l1 || m_l2);
        exp_stall = 1'b0;
        exp_flush = 1'b0;
        m_acc     = 1'b0;
        if (!rst_n) begin
            exp_stall = 1'b0;
        end else if (m_sq_rem > 0) begin
            exp_flush = 1'b1;
            m_acc     = redirect;
        end else if (m_mc) begin
            exp_stall = !mc_done;
        end else if (redirect) begin
            exp_flush = 1'b1;
            m_acc     = 1'b1;
        end else begin
            exp_stall = m_lu;
        end
    endtask

    task automatic model_reset();
        m_sq_rem = 0;
        m_mc     = 1'b0;
        m_sc     = 0;
        m_fe     = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst_n) begin
            if (cnt_clr) begin
                m_sc = 0;
                m_fe = 0;
            end else begin
                if (exp_stall && m_sc < MAXC) m_sc++;
                if (m_acc && m_fe < MAXC)     m_fe++;
            end
            if (m_sq_rem > 0) begin
                if (redirect) m_sq_rem = FLUSH_DEPTH;
                else          m_sq_rem--;
            end else if (m_mc) begin
                if (mc_done) m_mc = 1'b0;
            end else if (redirect) begin
                m_sq_rem = FLUSH_DEPTH;
            end else if (mc_start && de_valid && !m_lu) begin
                m_mc = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drive_idle();
        de_valid = 0; de_use_rs1 = 0; de_use_rs2 = 0;
        de_rs1 = '0; de_rs2 = '0; de_rs1_data = '0; de_rs2_data = '0;
        src_rd = '0; src_we = '0; src_is_load = '0; src_data = '0;
        redirect = 0; mc_start = 0; mc_done = 0; cnt_clr = 0;
    endtask

    task automatic drive_load_use_x7();
        de_valid = 1; de_use_rs1 = 1; de_rs1 = 5'd7;
        src_rd = {5'd0, 5'd7}; src_we = 2'b01; src_is_load = 2'b01;
        src_data = {32'h0, 32'h1234};
    endtask

    task automatic clear_counters();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        model_reset();
        rst_n = 0;
        drive_load_use_x7();
        #3;
        checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o); else passed++;
        checks++; if (flush_o !== 1'b0) $display("FAIL reset_flush: got %b expected 0", flush_o); else passed++;
        checks++; if (stall_cycles_o !== '0 || flush_events_o !== '0)
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles_o, flush_events_o); else passed++;
        checks++; if (rs1_o !== 32'h1234) $display("FAIL reset_rs1_comb: got %h expected 00001234", rs1_o); else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else passed++;
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (stall_o !== 1'b1) $display("FAIL reset_release_stall: got %b expected 1", stall_o); else passed++;
        tick();
        drive_idle();
        clear_counters();
    endtask

    task automatic test_fwd_priority();
        drive_idle();
        de_valid = 1; de_use_rs1 = 1; de_rs1 = 5'd5;
        de_use_rs2 = 1; de_rs2 = 5'd6; de_rs2_data = 32'h600D;
        src_rd = {5'd5, 5'd5}; src_we = 2'b11; src_data = {32'hBBBB, 32'hAAAA};
        #1;
        checks++; if (rs1_o !== 32'hAAAA) $display("FAIL fwd_stage0: got %h expected 0000aaaa", rs1_o); else passed++;
        checks++; if (rs2_o !== 32'h600D) $display("FAIL fwd_nomatch_rf: got %h expected 0000600d", rs2_o); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL fwd_no_stall: got %b expected 0", stall_o); else passed++;
        tick();
        src_we = 2'b10;
        #1;
        checks++; if (rs1_o !== 32'hBBBB) $display("FAIL fwd_stage1: got %h expected 0000bbbb", rs1_o); else passed++;
        tick();
        drive_idle();
    endtask

    task automatic test_x0();
        drive_idle();
        de_valid = 1; de_use_rs2 = 1; de_rs2 = 5'd0; de_rs2_data = '0;
        src_rd = {5'd0, 5'd0}; src_we = 2'b01; src_is_load = 2'b01; src_data = {32'h0, 32'hDEAD};
        #1;
        checks++; if (rs2_o !== 32'h0) $display("FAIL x0_rs2: got %h expected 00000000", rs2_o); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL x0_stall: got %b expected 0", stall_o); else passed++;
        tick();
        drive_idle();
    endtask

    task automatic test_load_use();
        drive_idle();
        clear_counters();
        drive_load_use_x7();
        #1;
        checks++; if (stall_o !== 1'b1) $display("FAIL lu_stage0_stall: got %b expected 1", stall_o); else passed++;
        tick();
        src_rd = {5'd7, 5'd0}; src_we = 2'b10; src_is_load = 2'b10; src_data = {32'h7777, 32'h0};
        #1;
        checks++; if (stall_o !== 1'b0) $display("FAIL lu_stage1_stall: got %b expected 0", stall_o); else passed++;
        checks++; if (rs1_o !== 32'h7777) $display("FAIL lu_stage1_fwd: got %h expected 00007777", rs1_o); else passed++;
        checks++; if (stall_cycles_o !== 4'd1) $display("FAIL lu_stall_cycles: got %0d expected 1", stall_cycles_o); else passed++;
        tick();
        drive_idle();
    endtask

    task automatic test_multicycle();
        int n;
        drive_idle();
        clear_counters();
        de_valid = 1; mc_start = 1;
        #1;
        checks++; if (stall_o !== 1'b0) $display("FAIL mc_issue_stall: got %b expected 0", stall_o); else passed++;
        tick();
        drive_idle();
        n = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (stall_o === 1'b1) n++;
            tick();
        end
        checks++; if (n !== 4) $display("FAIL mc_wait_stalls: got %0d expected 4", n); else passed++;
        mc_done = 1;
        #1;
        checks++; if (stall_o !== 1'b0) $display("FAIL mc_done_stall: got %b expected 0", stall_o); else passed++;
        tick();
        mc_done = 0;
        #1;
        checks++; if (stall_cycles_o !== 4'd4) $display("FAIL mc_stall_cycles: got %0d expected 4", stall_cycles_o); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL mc_back_in_run: got %b expected 0", stall_o); else passed++;
    endtask

    task automatic test_redirect();
        int n;
        int bad_stall;
        drive_idle();
        clear_counters();
        drive_load_use_x7();
        redirect = 1;
        #1;
        checks++; if (flush_o !== 1'b1 || stall_o !== 1'b0)
            $display("FAIL rd_wins: got flush=%b stall=%b expected flush=1 stall=0", flush_o, stall_o); else passed++;
        tick();
        redirect = 0;
        drive_idle();
        n = 0; bad_stall = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (flush_o !== 1'b1) break;
            if (stall_o !== 1'b0) bad_stall++;
            n++;
            tick();
        end
        checks++; if (n !== FLUSH_DEPTH || bad_stall !== 0)
            $display("FAIL rd_squash_len: got %0d cycles (%0d stalls) expected %0d (0)", n, bad_stall, FLUSH_DEPTH); else passed++;
        checks++; if (flush_events_o !== 4'd1) $display("FAIL rd_events1: got %0d expected 1", flush_events_o); else passed++;
        tick();
        clear_counters();
        redirect = 1;
        tick();
        // second redirect lands in the first squash cycle
        #1;
        n = (flush_o === 1'b1) ? 1 : 0;
        tick();
        redirect = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (flush_o !== 1'b1) break;
            n++;
            tick();
        end
        checks++; if (n !== FLUSH_DEPTH + 1) $display("FAIL rd_extend_len: got %0d expected %0d", n, FLUSH_DEPTH + 1); else passed++;
        checks++; if (flush_events_o !== 4'd2) $display("FAIL rd_events2: got %0d expected 2", flush_events_o); else passed++;
        tick();
    endtask

    task automatic test_saturation();
        int n;
        drive_idle();
        clear_counters();
        drive_load_use_x7();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (stall_o === 1'b1) n++;
            tick();
        end
        drive_idle();
        #1;
        checks++; if (n !== 20) $display("FAIL sat_stall_held: got %0d expected 20", n); else passed++;
        checks++; if (stall_cycles_o !== 4'd15) $display("FAIL sat_value: got %0d expected 15", stall_cycles_o); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_mc();
        drive_idle();
        de_valid = 1; mc_start = 1;
        tick();
        drive_idle();
        tick();
        #1;
        checks++; if (stall_o !== 1'b1) $display("FAIL rmc_waiting: got %b expected 1", stall_o); else passed++;
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        checks++; if (stall_o !== 1'b0) $display("FAIL rmc_stall_async: got %b expected 0", stall_o); else passed++;
        checks++; if (stall_cycles_o !== '0 || flush_events_o !== '0)
            $display("FAIL rmc_counters: got %0d/%0d expected 0/0", stall_cycles_o, flush_events_o); else passed++;
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        checks++; if (stall_o !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL rmc_after_release: got stall=%b state=%0d expected 0/0", stall_o, dbg_state); else passed++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            de_valid    = ($urandom_range(0, 3) != 0);
            de_use_rs1  = $urandom_range(0, 1);
            de_use_rs2  = $urandom_range(0, 1);
            de_rs1      = 5'($urandom_range(0, 3));
            de_rs2      = 5'($urandom_range(0, 3));
            de_rs1_data = $urandom;
            de_rs2_data = $urandom;
            src_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            src_we      = 2'($urandom_range(0, 3));
            src_is_load = 2'($urandom_range(0, 3));
            src_data    = {$urandom, $urandom};
            redirect    = ($urandom_range(0, 9) == 0);
            mc_start    = ($urandom_range(0, 4) == 0);
            mc_done     = ($urandom_range(0, 3) == 0);
            cnt_clr     = ($urandom_range(0, 49) == 0);
            #1;
            model_eval();
            checks++; if (stall_o !== exp_stall) $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall_o, exp_stall); else passed++;
            checks++; if (flush_o !== exp_flush) $display("FAIL rnd_flush c=%0d: got %b expected %b", c, flush_o, exp_flush); else passed++;
            if (!m_l1) begin
                checks++; if (rs1_o !== exp_rs1) $display("FAIL rnd_rs1 c=%0d: got %h expected %h", c, rs1_o, exp_rs1); else passed++;
            end
            if (!m_l2) begin
                checks++; if (rs2_o !== exp_rs2) $display("FAIL rnd_rs2 c=%0d: got %h expected %h", c, rs2_o, exp_rs2); else passed++;
            end
            checks++; if (stall_cycles_o !== CW'(m_sc)) $display("FAIL rnd_stall_cnt c=%0d: got %0d expected %0d", c, stall_cycles_o, m_sc); else passed++;
            checks++; if (flush_events_o !== CW'(m_fe)) $display("FAIL rnd_flush_cnt c=%0d: got %0d expected %0d", c, flush_events_o, m_fe); else passed++;
            tick();
        end
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fwd_priority();
        test_x0();
        test_load_use();
        test_multicycle();
        test_redirect();
        test_saturation();
        test_reset_mid_mc();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter XLEN, default 32: datapath width of forwarded operands.
REQ-002 Parameter NFWD, default 2: number of forwarding source stages; index 0 = EX (youngest), NFWD-1 = oldest.
REQ-003 Parameter LOAD_LAT, default 1: a load in source index k < LOAD_LAT cannot forward; range 0..NFWD.
REQ-004 Parameter FLUSH_DEPTH, default 2: number of cycles squashed after a redirect; minimum 1.
REQ-005 Parameter CW, default 32: width of the performance counters.
REQ-006 CLK  in  1  single clock; all state updates on rising edge.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 DE_VALID  in  1  decode-stage instruction is valid (not flushed).
REQ-009 DE_RS1, DE_RS2  in  5 each  decode source register addresses.
REQ-010 DE_USE_RS1, DE_USE_RS2  in  1 each  source is actually read by the instruction.
REQ-011 DE_RS1_DATA, DE_RS2_DATA  in  XLEN each  register-file read data.
REQ-012 SRC_RD  in  5*NFWD  destination address per source stage, stage i at bits [5i+4:5i].
REQ-013 SRC_WE  in  NFWD  stage i will write its destination.
REQ-014 SRC_IS_LOAD  in  NFWD  stage i holds a load.
REQ-015 SRC_DATA  in  XLEN*NFWD  result available at stage i.
REQ-016 REDIRECT  in  1  valid control transfer resolved in EX this cycle.
REQ-017 MC_START  in  1  decode issues a multi-cycle operation.
REQ-018 MC_DONE  in  1  multi-cycle unit result ready (single-cycle pulse).
REQ-019 CNT_CLR  in  1  synchronous clear of the performance counters.
REQ-020 RS1_OUT, RS2_OUT  out  XLEN each  hazard-protected operands.
REQ-021 STALL  out  1  hold PC and IF/DE registers, insert bubble into EX.
REQ-022 FLUSH  out  1  squash the instructions in IF and DE.
REQ-023 STALL_CYCLES, FLUSH_EVENTS  out  CW each  saturating performance counters.

Function
REQ-024 Forwarding SHALL be combinational: for each source, the lowest index i with SRC_WE[i], SRC_RD[i]==address, address!=0 and DE_USE set wins; no match selects DE_RSx_DATA.
REQ-025 Address x0 SHALL never forward nor cause a stall.
REQ-026 Load-use hazard SHALL be: DE_VALID and the winning match i has SRC_IS_LOAD[i] and i < LOAD_LAT; operand value is then don't-care.
REQ-027 FSM states SHALL be RUN, MC_WAIT, SQUASH.
REQ-028 RUN: REDIRECT -> SQUASH; else MC_START and DE_VALID and no load-use -> MC_WAIT; else stay.
REQ-029 In RUN, STALL SHALL equal the load-use hazard term; FLUSH SHALL equal REDIRECT.
REQ-030 MC_WAIT: STALL=1 every cycle until MC_DONE; in the MC_DONE cycle STALL=0 and next state RUN.
REQ-031 REDIRECT in MC_WAIT SHALL be ignored (protocol violation, no state effect).
REQ-032 SQUASH: FLUSH=1, STALL=0, load-use and MC_START ignored; a down-counter loaded with FLUSH_DEPTH-1 on entry returns to RUN when it reaches 0; FLUSH_DEPTH=1 returns in one cycle.
REQ-033 REDIRECT in SQUASH SHALL reload the counter to FLUSH_DEPTH-1 and increment FLUSH_EVENTS.
REQ-034 Simultaneous REDIRECT and load-use/MC_START in RUN: REDIRECT wins, STALL=0.
REQ-035 STALL_CYCLES SHALL increment each cycle STALL=1; FLUSH_EVENTS SHALL increment each accepted REDIRECT; both saturate at all-ones.
REQ-036 CNT_CLR SHALL zero both counters and take priority over increment in the same cycle.

Reset
REQ-037 RST_N low SHALL immediately force state RUN, squash counter 0, both counters 0, independent of CLK.
REQ-038 During reset STALL=0 and FLUSH=0; RS1_OUT/RS2_OUT remain combinational.
REQ-039 Reset asserted mid-MC_WAIT or mid-SQUASH SHALL abandon the operation; first cycle after release is RUN.

Verification
REQ-040 Forward priority: NFWD=2, SRC_RD=(x5,x5), SRC_WE=11, SRC_DATA=(0xAAAA,0xBBBB), DE_RS1=x5 -> RS1_OUT=0xAAAA (stage 0); SRC_WE=10 -> 0xBBBB.
REQ-041 x0: DE_RS2=x0, SRC_RD[0]=x0, SRC_WE[0]=1, DE_RS2_DATA=0 -> RS2_OUT=0, STALL=0.
REQ-042 Load-use: LOAD_LAT=1, stage 0 load to x7, DE_RS1=x7 -> STALL=1 one cycle, STALL_CYCLES=1; same load in stage 1 -> forwarded, STALL=0.
REQ-043 Multi-cycle: MC_START then MC_DONE 4 cycles later -> STALL high 4 cycles, low on MC_DONE cycle, STALL_CYCLES=4.
REQ-044 Redirect: FLUSH_DEPTH=2, REDIRECT one cycle with concurrent load-use -> FLUSH=1 for 2 cycles, STALL=0, FLUSH_EVENTS=1; second REDIRECT in SQUASH extends to 3 cycles total, FLUSH_EVENTS=2.
REQ-045 Saturation/reset: CW=4, 20 stall cycles -> STALL_CYCLES=15; RST_N low mid-MC_WAIT -> STALL=0 immediately, counters 0.
